// File: rtl/imem_pkg.sv
// Shared defaults for the instruction memory and the neighbouring fetch/decode stages.
package imem_pkg;

    localparam int              DATA_W_DEF   = 16;
    localparam int              ADDR_W_DEF   = 16;
    localparam int              DEPTH_DEF    = 32;
    localparam logic [15:0]     NOP_WORD_DEF = 16'h0000;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } imem_state_e;

endpackage

// File: rtl/imem_ram.sv
// Single-clock RAM, one write port and one registered read port with read-before-write.
module imem_ram #(
    parameter int                DATA_W  = 16,
    parameter int                DEPTH   = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic                       i_re,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [DATA_W-1:0]          o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The read register is reset so the response path never shows X before the first fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= RST_VAL;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_fetch.sv
// Synchronous instruction memory with program-load port and 1-cycle valid/ready fetch.
//   state   | meaning
//   ST_INIT | clearing mem[clr_cnt] to NOP, one entry per cycle; no loads or fetches
//   ST_RUN  | loads and fetches accepted
module imem_fetch
    import imem_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DEPTH    = DEPTH_DEF,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_done,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic              rsp_fault,
    output logic [ADDR_W-1:0] rsp_pc
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0]  DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    imem_state_e       r_state;
    imem_state_e       w_state_nxt;
    logic [IDX_W-1:0]  r_clr_cnt;
    logic              w_clr_en;
    logic              w_run;

    logic              w_ld_in_range;
    logic              w_req_in_range;
    logic              w_req_accept;

    logic              w_ram_we;
    logic [IDX_W-1:0]  w_ram_waddr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;

    logic              r_rsp_valid;
    logic              r_rsp_fault;
    logic [ADDR_W-1:0] r_rsp_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_clr_cnt == LAST_IDX) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        w_clr_en = 1'b0;
        w_run    = 1'b0;
        case (r_state)
            ST_INIT: w_clr_en = 1'b1;
            ST_RUN:  w_run    = 1'b1;
            default: w_clr_en = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt <= '0;
        end else if (w_clr_en) begin
            r_clr_cnt <= r_clr_cnt + IDX_W'(1);
        end
    end

    // Range checks use the full PC width so high addresses never alias into the array.
    assign w_ld_in_range  = ({1'b0, ld_addr} < DEPTH_W);
    assign w_req_in_range = ({1'b0, req_pc}  < DEPTH_W);

    assign req_ready    = w_run && (!r_rsp_valid || rsp_ready);
    assign w_req_accept = req_valid && req_ready;

    assign w_ram_we    = w_clr_en || (w_run && ld_en && w_ld_in_range);
    assign w_ram_waddr = w_clr_en ? r_clr_cnt : ld_addr[IDX_W-1:0];
    assign w_ram_wdata = w_clr_en ? NOP_WORD  : ld_data;

    imem_ram #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .RST_VAL (NOP_WORD)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_req_accept && w_req_in_range),
        .i_raddr (req_pc[IDX_W-1:0]),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_pc    <= '0;
        end else if (w_req_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= !w_req_in_range;
            r_rsp_pc    <= req_pc;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign init_done = w_run;
    assign ld_ready  = w_run;
    assign rsp_valid = r_rsp_valid;
    assign rsp_fault = r_rsp_fault;
    assign rsp_pc    = r_rsp_pc;
    // Out-of-range fetches skip the RAM read, so the NOP is substituted here.
    assign rsp_instr = r_rsp_fault ? NOP_WORD : w_ram_rdata;

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: clear, load, fetch handshake, stalls, faults, collisions, reset.
module tb_imem_fetch;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done;
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        ld_ready;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_pc = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_instr;
    logic        rsp_fault;
    logic [15:0] rsp_pc;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_mem [DEPTH];

    imem_fetch #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .DEPTH    (DEPTH),
        .NOP_WORD (16'h0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault),
        .rsp_pc    (rsp_pc)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until init_done, bounded; also counts cycles where req_ready leaked high.
    task automatic wait_init(output int n, output int rr_bad);
        n = 0;
        rr_bad = 0;
        while (!init_done && n < 64) begin
            if (req_ready) rr_bad++;
            tick();
            n++;
        end
    endtask

    task automatic fetch_chk(input string tag, input logic [15:0] pc,
                             input logic [15:0] exp_instr, input logic exp_fault);
        req_valid = 1'b1;
        req_pc    = pc;
        tick();
        chk_val(tag, {rsp_valid, rsp_fault, rsp_pc, rsp_instr},
                     {1'b1, exp_fault, pc, exp_instr});
    endtask

    task automatic idle_chk(input string tag);
        req_valid = 1'b0;
        ld_en     = 1'b0;
        tick();
        chk_val(tag, rsp_valid, 1'b0);
    endtask

    initial begin
        int n;
        int rr_bad;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 16'h0000;

        #1;
        chk_val("rst_rsp", {rsp_valid, rsp_fault, rsp_pc, rsp_instr}, '0);
        repeat (3) tick();
        chk_val("rst_ctrl", {init_done, ld_ready, req_ready}, 3'b000);

        // A load issued during clearing must be ignored.
        ld_en = 1'b1; ld_addr = 16'd3; ld_data = 16'hFFFF;
        rst_n = 1'b1;
        wait_init(n, rr_bad);
        ld_en = 1'b0;
        chk_val("init_cycles", 64'(n), 64'd32);
        chk_val("init_req_ready", 64'(rr_bad), 64'd0);
        chk_val("run_ready", {ld_ready, req_ready}, 2'b11);

        for (int i = 0; i < DEPTH; i++) fetch_chk("clear_sweep", 16'(i), 16'h0000, 1'b0);
        idle_chk("drain_after_sweep");

        ld_en = 1'b1; ld_addr = 16'd4; ld_data = 16'h0AB3; tick();
        ld_addr = 16'd5; ld_data = 16'h4750; tick();
        ld_en = 1'b0;
        exp_mem[4] = 16'h0AB3;
        exp_mem[5] = 16'h4750;
        fetch_chk("b2b_pc4", 16'd4, 16'h0AB3, 1'b0);
        fetch_chk("b2b_pc5", 16'd5, 16'h4750, 1'b0);

        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc    = 16'd9;
        #1;
        chk_val("stall_req_ready0", req_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_val("stall_hold", {rsp_valid, rsp_fault, rsp_pc, rsp_instr},
                                  {1'b1, 1'b0, 16'd5, 16'h4750});
            chk_val("stall_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        req_pc    = 16'd4;
        #1;
        chk_val("release_req_ready", req_ready, 1'b1);
        tick();
        chk_val("release_no_bubble", {rsp_valid, rsp_fault, rsp_pc, rsp_instr},
                                     {1'b1, 1'b0, 16'd4, 16'h0AB3});
        idle_chk("drain_after_stall");

        fetch_chk("oor_pc32", 16'd32, 16'h0000, 1'b1);
        fetch_chk("oor_pcffff", 16'hFFFF, 16'h0000, 1'b1);
        idle_chk("drain_after_oor");
        ld_en = 1'b1; ld_addr = 16'd40; ld_data = 16'hBEEF; tick();
        ld_addr = 16'hFFFF; ld_data = 16'h1111; tick();
        ld_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) fetch_chk("model_sweep", 16'(i), exp_mem[i], 1'b0);
        idle_chk("drain_after_model");

        ld_en = 1'b1; ld_addr = 16'd7; ld_data = 16'h1234;
        fetch_chk("collide_old", 16'd7, 16'h0000, 1'b0);
        ld_en = 1'b0;
        exp_mem[7] = 16'h1234;
        fetch_chk("collide_new", 16'd7, 16'h1234, 1'b0);
        idle_chk("drain_after_collide");

        rsp_ready = 1'b0;
        fetch_chk("pre_rst", 16'd4, 16'h0AB3, 1'b0);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_val("async_rst_rsp", {rsp_valid, rsp_fault, rsp_pc, rsp_instr}, '0);
        chk_val("async_rst_ctrl", {init_done, ld_ready, req_ready}, 3'b000);
        tick();
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        wait_init(n, rr_bad);
        chk_val("reinit_cycles", 64'(n), 64'd32);
        chk_val("reinit_req_ready", 64'(rr_bad), 64'd0);
        fetch_chk("lost_pc4", 16'd4, 16'h0000, 1'b0);
        fetch_chk("lost_pc5", 16'd5, 16'h0000, 1'b0);
        fetch_chk("lost_pc7", 16'd7, 16'h0000, 1'b0);
        idle_chk("drain_final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
